// File: rtl/demux_1to4_buf_if.sv
// Handshake bundle for demux_1to4_buf: one upstream valid/ready port and four
// buffered downstream channels. master = upstream producer plus downstream consumers.
interface demux_1to4_buf_if #(
    parameter int INPUT_SIZE = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [INPUT_SIZE-1:0] in_data;
    logic [1:0]            sel;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [INPUT_SIZE-1:0] out_data_0;
    logic [INPUT_SIZE-1:0] out_data_1;
    logic [INPUT_SIZE-1:0] out_data_2;
    logic [INPUT_SIZE-1:0] out_data_3;

    modport master (
        output in_valid, in_data, sel, out_ready,
        input  in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3
    );

    modport slave (
        input  in_valid, in_data, sel, out_ready,
        output in_ready, out_valid, out_data_0, out_data_1, out_data_2, out_data_3
    );
endinterface

// File: rtl/demux_1to4_buf.sv
// 1-to-4 demultiplexer with a one-entry buffer per channel, full throughput per channel.
// Optional macro DEMUX_1TO4_CNT_EN adds a 16-bit wrapping count of accepted input words.
//
// state | meaning
// EMPTY | channel holds no word; out_data_k is stale and must be ignored
// FULL  | channel holds a word; out_valid[k]=1 and out_data_k is stable until drained
module demux_1to4_buf #(
    parameter int INPUT_SIZE = 32
) (
    input  logic              clk,
    input  logic              rst,
    demux_1to4_buf_if.slave   bus
`ifdef DEMUX_1TO4_CNT_EN
    ,
    output logic [15:0]       route_cnt
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_e;

    ch_state_e             state_q [4];
    ch_state_e             state_d [4];
    logic [INPUT_SIZE-1:0] data_q  [4];
    logic [INPUT_SIZE-1:0] data_d  [4];
    logic                  in_ready;
    logic                  in_fire;
    logic [3:0]            out_valid;

    // A full channel can still accept when its consumer drains on the same edge.
    always_comb begin
        in_ready  = (state_q[bus.sel] == EMPTY) || bus.out_ready[bus.sel];
        in_fire   = bus.in_valid && in_ready;
        out_valid = '0;
        for (int k = 0; k < 4; k++) begin
            state_d[k]   = state_q[k];
            data_d[k]    = data_q[k];
            out_valid[k] = (state_q[k] == FULL);
            if (in_fire && (bus.sel == 2'(k))) begin
                state_d[k] = FULL;
                data_d[k]  = bus.in_data;
            end else if ((state_q[k] == FULL) && bus.out_ready[k]) begin
                state_d[k] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= EMPTY;
                data_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                state_q[k] <= state_d[k];
                data_q[k]  <= data_d[k];
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data_0 = data_q[0];
    assign bus.out_data_1 = data_q[1];
    assign bus.out_data_2 = data_q[2];
    assign bus.out_data_3 = data_q[3];

`ifdef DEMUX_1TO4_CNT_EN
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    assign cnt_d = in_fire ? cnt_q + 16'd1 : cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign route_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_demux_1to4_buf.sv
// Self-checking bench for demux_1to4_buf: directed scenario tasks plus a per-channel
// scoreboard that tracks accepted words and checks them as they drain.
module tb_demux_1to4_buf;

    localparam int W = 32;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    demux_1to4_buf_if #(.INPUT_SIZE(W)) bus ();

`ifdef DEMUX_1TO4_CNT_EN
    logic [15:0] route_cnt;
    demux_1to4_buf #(.INPUT_SIZE(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .route_cnt (route_cnt)
    );
`else
    demux_1to4_buf #(.INPUT_SIZE(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] sb_q [4][$];

    function automatic logic [W-1:0] od(input int k);
        case (k)
            0: return bus.out_data_0;
            1: return bus.out_data_1;
            2: return bus.out_data_2;
            default: return bus.out_data_3;
        endcase
    endfunction

    // Scoreboard monitor: evaluates the transfers that the coming rising edge will perform.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                for (int k = 0; k < 4; k++) sb_q[k].delete();
            end else begin
                logic exp_rdy;
                exp_rdy = (sb_q[bus.sel].size() == 0) || bus.out_ready[bus.sel];
                checks++;
                if (bus.in_ready !== exp_rdy) begin
                    errors++;
                    $display("FAIL sb_in_ready: got %b expected %b (sel=%0d)", bus.in_ready, exp_rdy, bus.sel);
                end
                for (int k = 0; k < 4; k++) begin
                    checks++;
                    if (bus.out_valid[k] !== (sb_q[k].size() != 0)) begin
                        errors++;
                        $display("FAIL sb_out_valid[%0d]: got %b expected %b", k, bus.out_valid[k], sb_q[k].size() != 0);
                    end
                    if (bus.out_ready[k] && sb_q[k].size() != 0) begin
                        logic [W-1:0] exp_w;
                        exp_w = sb_q[k].pop_front();
                        checks++;
                        if (od(k) !== exp_w) begin
                            errors++;
                            $display("FAIL sb_data[%0d]: got %h expected %h", k, od(k), exp_w);
                        end
                    end
                end
                if (bus.in_valid && exp_rdy) sb_q[bus.sel].push_back(bus.in_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sel       = 2'd0;
        bus.out_ready = 4'b0000;
    endtask

    task automatic load(input logic [1:0] s, input logic [W-1:0] d);
        bus.sel      = s;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain_all();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b1111;
        step();
        bus.out_ready = 4'b0000;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        mon_en = 1'b1;
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL reset_out_valid: got %b expected 0000", bus.out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (od(k) !== '0) begin
                errors++; $display("FAIL reset_out_data[%0d]: got %h expected 0", k, od(k));
            end
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_basic_route();
        bus.out_ready = 4'b0000;
        load(2'b10, 32'hA5A5_A5A5);
        checks++;
        if (bus.out_valid !== 4'b0100) begin
            errors++; $display("FAIL basic_out_valid: got %b expected 0100", bus.out_valid);
        end
        checks++;
        if (bus.out_data_2 !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL basic_out_data_2: got %h expected a5a5a5a5", bus.out_data_2);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL basic_in_ready_blocked: got %b expected 0", bus.in_ready);
        end
        drain_all();
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL basic_drained: got %b expected 0000", bus.out_valid);
        end
    endtask

    task automatic test_stall_and_replace();
        load(2'b01, 32'h1111_1111);
        bus.sel      = 2'b01;
        bus.in_data  = 32'h2222_2222;
        bus.in_valid = 1'b1;
        bus.out_ready = 4'b0000;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL stall_in_ready: got %b expected 0", bus.in_ready);
        end
        step();
        checks++;
        if (bus.out_data_1 !== 32'h1111_1111 || bus.out_valid !== 4'b0010) begin
            errors++; $display("FAIL stall_hold: got %h/%b expected 11111111/0010", bus.out_data_1, bus.out_valid);
        end
        bus.out_ready = 4'b0010;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL replace_in_ready: got %b expected 1", bus.in_ready);
        end
        step();
        bus.in_valid  = 1'b0;
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.out_data_1 !== 32'h2222_2222 || bus.out_valid !== 4'b0010) begin
            errors++; $display("FAIL replace_load: got %h/%b expected 22222222/0010", bus.out_data_1, bus.out_valid);
        end
        drain_all();
    endtask

    task automatic test_independent_channels();
        logic [W-1:0] words [3];
        words[0] = 32'h0000_00C0;
        words[1] = 32'h0000_00C1;
        words[2] = 32'h0000_00C2;
        bus.out_ready = 4'b0000;
        load(2'b11, 32'h3333_3333);
        bus.out_ready = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            load(2'(i), words[i]);
            checks++;
            if (bus.out_valid[i] !== 1'b1 || od(i) !== words[i]) begin
                errors++; $display("FAIL indep_word%0d: got %b/%h expected 1/%h", i, bus.out_valid[i], od(i), words[i]);
            end
            checks++;
            if (bus.out_valid[3] !== 1'b1 || bus.out_data_3 !== 32'h3333_3333) begin
                errors++; $display("FAIL indep_ch3_hold: got %b/%h expected 1/33333333", bus.out_valid[3], bus.out_data_3);
            end
        end
        step();
        checks++;
        if (bus.out_valid !== 4'b1000) begin
            errors++; $display("FAIL indep_drained: got %b expected 1000", bus.out_valid);
        end
        bus.sel = 2'b11;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL indep_ch3_blocks: got %b expected 0", bus.in_ready);
        end
        bus.sel = 2'b00;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL indep_ch0_open: got %b expected 1", bus.in_ready);
        end
        drain_all();
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        bus.out_ready = 4'b0001;
        bus.sel       = 2'b00;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = $urandom();
            bus.in_data = w;
            #1;
            checks++;
            if (bus.in_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", i, bus.in_ready);
            end
            step();
            checks++;
            if (bus.out_valid[0] !== 1'b1 || bus.out_data_0 !== w) begin
                errors++; $display("FAIL b2b_word[%0d]: got %b/%h expected 1/%h", i, bus.out_valid[0], bus.out_data_0, w);
            end
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 4'b0000;
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL b2b_drained: got %b expected 0000", bus.out_valid);
        end
    endtask

    task automatic test_reset_full();
        bus.out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) load(2'(k), 32'hF000_0000 + k);
        checks++;
        if (bus.out_valid !== 4'b1111) begin
            errors++; $display("FAIL rstfull_pre: got %b expected 1111", bus.out_valid);
        end
        bus.out_ready = 4'b1111;
        bus.in_valid  = 1'b1;
        bus.sel       = 2'b01;
        bus.in_data   = 32'hDEAD_BEEF;
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if (bus.out_valid !== 4'b0000) begin
            errors++; $display("FAIL rstfull_out_valid: got %b expected 0000", bus.out_valid);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (od(k) !== '0) begin
                errors++; $display("FAIL rstfull_out_data[%0d]: got %h expected 0", k, od(k));
            end
        end
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rstfull_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

`ifdef DEMUX_1TO4_CNT_EN
    task automatic test_route_cnt();
        checks++;
        if (route_cnt !== 16'h0000) begin
            errors++; $display("FAIL cnt_reset: got %h expected 0000", route_cnt);
        end
        bus.out_ready = 4'b0001;
        bus.sel       = 2'b00;
        bus.in_valid  = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            bus.in_data = 32'(i);
            step();
        end
        checks++;
        if (route_cnt !== 16'hFFFE) begin
            errors++; $display("FAIL cnt_preload: got %h expected fffe", route_cnt);
        end
        step();
        step();
        checks++;
        if (route_cnt !== 16'h0000) begin
            errors++; $display("FAIL cnt_wrap: got %h expected 0000", route_cnt);
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 4'b0000;
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_basic_route();
        test_stall_and_replace();
        test_independent_channels();
        test_back_to_back();
        test_reset_full();
`ifdef DEMUX_1TO4_CNT_EN
        test_route_cnt();
`endif
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux_1to4_buf.md
DEMUX_1TO4_BUF -- requirements
Module: demux_1to4_buf

Interface
REQ-001 The block SHALL have parameter INPUT_SIZE, default 32, setting the data width of the input and each output channel.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream word is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-006 The block SHALL have port in_data, input, INPUT_SIZE bits: the upstream word.
REQ-007 The block SHALL have port sel, input, 2 bits: the destination channel index, meaningful only while in_valid=1.
REQ-008 The block SHALL have port out_valid, output, 4 bits: bit k means channel k holds a word.
REQ-009 The block SHALL have port out_ready, input, 4 bits: bit k means the channel k consumer takes the word this cycle.
REQ-010 The block SHALL have ports out_data_0..out_data_3, output, INPUT_SIZE bits each: the channel k held word.

Function
REQ-011 Each channel SHALL be a one-entry buffer with state EMPTY or FULL, and out_valid[k] SHALL be 1 exactly when channel k is FULL.
REQ-012 sel SHALL map one-to-one to channels: 00 to ch0, 01 to ch1, 10 to ch2, 11 to ch3.
REQ-013 in_ready SHALL equal (channel[sel] EMPTY) OR out_ready[sel], combinationally from current state, out_ready and sel, with no dependence on in_valid.
REQ-014 An input transfer SHALL occur when in_valid AND in_ready are both 1; on that edge in_data is stored into channel sel and that channel becomes FULL.
REQ-015 An output transfer on channel k SHALL occur when out_valid[k] AND out_ready[k] are both 1; on that edge, with no simultaneous input transfer to k, the channel becomes EMPTY.
REQ-016 Simultaneous input and output transfer on the same channel SHALL keep it FULL and load the new word, giving full throughput of one word per cycle.
REQ-017 Latency SHALL be exactly 1 cycle: a word accepted on edge N SHALL be visible on out_data_sel with out_valid set after edge N.
REQ-018 While channel k is FULL and not drained, out_data_k SHALL remain stable.
REQ-019 Channels not addressed by sel SHALL drain independently; a stalled channel SHALL block input only while sel addresses it.
REQ-020 When a channel is EMPTY, out_data_k SHALL keep its last value and SHALL NOT be interpreted downstream.
REQ-021 The block SHALL never overwrite a FULL channel that is not draining, and SHALL never lose or duplicate a word.

Reset
REQ-022 While rst=1 at a clock edge, all channels SHALL become EMPTY, out_valid SHALL be 0000, and out_data_0..3 SHALL be 0.
REQ-023 Reset SHALL take priority over simultaneous transfers; held words SHALL be discarded, and no transfer SHALL be recorded that cycle.
REQ-024 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-025 With macro DEMUX_1TO4_CNT_EN defined, the block SHALL add output route_cnt, 16 bits, reset 0, incremented by 1 on each input transfer and wrapping from 0xFFFF to 0x0000.
REQ-026 Without DEMUX_1TO4_CNT_EN, the route_cnt port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-027 Reset then in_data=0xA5A5A5A5, sel=10, in_valid=1 for one cycle, out_ready=0000 -> next cycle out_valid=0100, out_data_2=0xA5A5A5A5, and in_ready=0 while sel=10.
REQ-028 Channel 1 FULL, out_ready=0000, sel=01, in_valid=1 -> in_ready=0 and out_data_1 unchanged; raise out_ready[1] -> in_ready=1, the new word loads, and ch1 stays FULL.
REQ-029 Channel 3 FULL and stalled, then stream sel=00, 01, 10 with out_ready=0111 -> three words delivered in order with 1-cycle latency, and ch3 is untouched.
REQ-030 Back-to-back input every cycle to sel=00 with out_ready[0]=1 for 8 cycles -> 8 words out in order, in_ready held at 1.
REQ-031 All four channels FULL, assert rst for one cycle -> out_valid=0000, all out_data=0, and in_ready=1 on the next cycle.
REQ-032 With DEMUX_1TO4_CNT_EN, preload route_cnt to 0xFFFE via 65534 transfers, then 2 more transfers -> route_cnt=0x0000.
